// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  localparam logic IDLE_LEVEL     = 1'b1;
  localparam int   MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP1  = 3'd4,
    TX_STOP2  = 3'd5,
    TX_BREAK  = 3'd6
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // Folds the two parity config pins into one mode value at accept time.
  function automatic parity_e par_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - data shift register, bit counter and parity accumulator
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load        capture load_data, clear counter and parity
//   shift       shift one data bit out (right), count it, fold it into parity
//   load_data   word to serialize, LSB first
//   bit_next    serial bit that will be on the line after this cycle's edge
//   last_bit    counter is at the final data bit
//   parity      even parity (XOR) of the whole loaded word, valid on the last bit
module uart_tx_shifter #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  bit_next,
  output logic                  last_bit,
  output logic                  parity
);
  import uart_pkg::*;

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;
  logic                  acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
      acc  <= 1'b0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
      acc  <= 1'b0;
    end else if (shift) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + CNT_W'(1);
      acc  <= acc ^ sreg[0];
    end
  end

  // The caller registers the line level on the same edge that shifts, so it
  // needs the post-shift LSB.
  assign bit_next = shift ? sreg[1] : sreg[0];
  assign last_bit = (cnt == CNT_W'(DATA_WIDTH - 1));
  // acc holds bits 0..W-2 once the counter reaches the last bit; the last
  // bit is still sitting in sreg[0].
  assign parity   = acc ^ sreg[0];

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame FSM with one-deep holding buffer
//
// Optional feature macro: UART_TX_BREAK_EN (adds tx_break input and BREAK state).
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   tick         one-cycle baud enable, one bit period per tick interval
//   tx_data      word to send, LSB first
//   tx_valid     source has a word
//   tx_ready     holding buffer empty; accept on tx_valid && tx_ready
//   par_en       parity bit enabled (sampled at accept)
//   par_odd      odd parity when 1, even when 0 (sampled at accept)
//   stop2        two stop bits when 1 (sampled at accept)
//   tx_break     (UART_TX_BREAK_EN only) hold the line low while high
//   tx_out       registered serial line, idle high
//   busy         registered, frame in progress
//   frame_done   one-cycle pulse after the tick that ends the last stop bit
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                  tx_break,
`endif
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);
  import uart_pkg::*;

  localparam logic [2:0] ST_IDLE   = TX_IDLE;
  localparam logic [2:0] ST_START  = TX_START;
  localparam logic [2:0] ST_DATA   = TX_DATA;
  localparam logic [2:0] ST_PARITY = TX_PARITY;
  localparam logic [2:0] ST_STOP1  = TX_STOP1;
  localparam logic [2:0] ST_STOP2  = TX_STOP2;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] ST_BREAK  = TX_BREAK;
`endif

  logic [2:0]            state;
  logic [2:0]            state_nxt;

  // Holding buffer: word plus its own config, frozen at accept.
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  parity_e               buf_par;
  logic                  buf_stop2;

  // Config of the frame on the wire; the buffer may be refilled meanwhile.
  parity_e               fr_par;
  logic                  fr_stop2;
`ifdef UART_TX_BREAK_EN
  logic                  fr_break;
`endif

  logic                  accept;
  logic                  enter_start;
  logic                  frame_end;
  logic                  tx_out_nxt;
  logic                  sh_shift;
  logic                  sh_bit;
  logic                  sh_last;
  logic                  sh_parity;

  assign tx_ready = !buf_full;
  assign accept   = tx_valid && tx_ready;
  assign sh_shift = tick && (state == ST_DATA);

  uart_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (enter_start),
    .shift     (sh_shift),
    .load_data (buf_data),
    .bit_next  (sh_bit),
    .last_bit  (sh_last),
    .parity    (sh_parity)
  );

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (buf_full) state_nxt = ST_START;
`ifdef UART_TX_BREAK_EN
          // A break request wins over a waiting word.
          if (tx_break) state_nxt = ST_BREAK;
`endif
        end
        ST_START:  state_nxt = ST_DATA;
        ST_DATA: begin
          if (sh_last) state_nxt = (fr_par != PAR_NONE) ? ST_PARITY : ST_STOP1;
        end
        ST_PARITY: state_nxt = ST_STOP1;
        ST_STOP1: begin
          if (fr_stop2) state_nxt = ST_STOP2;
          else          frame_end = 1'b1;
        end
        ST_STOP2:  frame_end = 1'b1;
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (!tx_break) state_nxt = ST_STOP1;
        end
`endif
        default:   state_nxt = ST_IDLE;
      endcase
      // Back-to-back: a waiting word starts right after the last stop bit.
      if (frame_end) state_nxt = buf_full ? ST_START : ST_IDLE;
    end
  end

  // Entering START only ever happens on a tick out of another state.
  assign enter_start = tick && (state_nxt == ST_START);

  always_comb begin
    tx_out_nxt = IDLE_LEVEL;
    case (state_nxt)
      ST_START:  tx_out_nxt = 1'b0;
      ST_DATA:   tx_out_nxt = sh_bit;
      ST_PARITY: tx_out_nxt = sh_parity ^ (fr_par == PAR_ODD);
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_out_nxt = 1'b0;
`endif
      default:   tx_out_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      buf_par    <= PAR_NONE;
      buf_stop2  <= 1'b0;
      fr_par     <= PAR_NONE;
      fr_stop2   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      fr_break   <= 1'b0;
`endif
      tx_out     <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      // Shifter and parity state move after the last data bit, so the line
      // level is only recomputed on ticks, when it was derived from them.
      if (tick) tx_out <= tx_out_nxt;
`ifdef UART_TX_BREAK_EN
      frame_done <= frame_end && !fr_break;
`else
      frame_done <= frame_end;
`endif

      if (enter_start) begin
        buf_full <= 1'b0;
        fr_par   <= buf_par;
        fr_stop2 <= buf_stop2;
`ifdef UART_TX_BREAK_EN
        fr_break <= 1'b0;
`endif
      end else if (accept) begin
        buf_full  <= 1'b1;
        buf_data  <= tx_data;
        buf_par   <= par_mode(par_en, par_odd);
        buf_stop2 <= stop2;
      end

`ifdef UART_TX_BREAK_EN
      if (tick && (state == ST_IDLE) && (state_nxt == ST_BREAK)) fr_break <= 1'b1;
      // A break is always closed with a single stop bit.
      if (tick && (state == ST_BREAK) && (state_nxt == ST_STOP1)) fr_stop2 <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Parametrised UART transmit controller: frame FSM, serializer, parity generator and one-deep holding buffer in one block.
- Generalises the fixed 8-bit TX FSM: configurable data width, even/odd/no parity, 1 or 2 stop bits, valid/ready input handshake, back-to-back frames with no idle gap.
- Sits between the TX data source (FIFO or register file) and the serial pin; bit timing comes from an external baud-tick generator.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_W, $clog2(DATA_WIDTH), width of the data bit counter; derived, never overridden.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle baud enable; one bit period = one tick interval.
- tx_data  in  DATA_WIDTH  word to send, LSB first.
- tx_valid  in  1  source has a word.
- tx_ready  out  1  holding buffer empty; word accepted when tx_valid && tx_ready.
- par_en  in  1  parity bit enabled; sampled at accept.
- par_odd  in  1  1 = odd parity, 0 = even; sampled at accept.
- stop2  in  1  1 = two stop bits; sampled at accept.
- tx_out  out  1  serial line, idle high, registered.
- busy  out  1  frame in progress, registered.
- frame_done  out  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Reset values: tx_out=1, busy=0, tx_ready=1, frame_done=0, state=IDLE, holding buffer empty.
- Holding buffer stores tx_data, par_en, par_odd, stop2. It is loaded on accept and cleared on the tick that moves to START. tx_ready = !buffer_full.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. State changes only on cycles with tick=1; each state lasts exactly one tick interval.
- IDLE -> START on tick with buffer full. An accept in the same cycle as that tick does not start the frame; START begins on the following tick.
- START -> DATA on tick. On START entry, the buffer moves into the shift register, the bit counter is cleared and the buffer frees (tx_ready=1 next cycle).
- DATA: on each tick, shift right and increment the counter. When counter == DATA_WIDTH-1 on tick, go to PARITY if par_en, else STOP1.
- PARITY -> STOP1 on tick.
- STOP1: on tick, go to STOP2 if stop2; else end the frame.
- STOP2: on tick, end the frame.
- End of frame: go to START if buffer full (back-to-back, no idle bit), else IDLE. frame_done=1 for the single cycle after that tick.
- tx_out is computed from the next state and registered, so it changes in the cycle after the tick:
  - IDLE, STOP1, STOP2 = 1; START = 0.
  - DATA = current shift-register LSB.
  - PARITY = XOR of the captured word, inverted when par_odd.
- busy = (next state != IDLE), registered.
- Config inputs change only at accept. A change mid-frame has no effect on the current frame.
- tick held high every cycle is legal; each state then lasts one clk cycle.
- Reset asserted mid-frame: next cycle all outputs return to reset values, the frame is aborted and the buffered word is discarded.
- tx_valid dropped without handshake: no effect.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input tx_break and state BREAK.
  - IDLE -> BREAK on tick when tx_break=1; tx_break takes priority over a full buffer.
  - In BREAK, tx_out=0 and busy=1; the buffer may still be filled.
  - On the first tick with tx_break=0: BREAK -> STOP1, always one stop bit, then normal end-of-frame handling.
  - frame_done does not pulse for a break.
- Undefined: port and state absent; behaviour as above.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_e;
  - parity enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - constants IDLE_LEVEL=1'b1 and MAX_DATA_WIDTH=9.
- Sub-module uart_tx_shifter: shift register, bit counter and parity accumulator; driven by load/shift from the FSM; outputs serial bit, last-bit flag and parity.
- FSM and holding buffer stay in the top.

Test Plan:
- Single frame: DATA_WIDTH=8, tx_data=8'hA5, par_en=0, stop2=0, tick every 16 cycles -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 16 cycles; busy high for the 10 bit periods; one frame_done pulse.
- Parity: 8'h03 with even parity -> parity bit 0; 8'h07 with odd parity -> parity bit 0; 8'h07 with even parity -> parity bit 1; frame is 11 bits.
- Back-to-back: 8'h55 then 8'hAA offered while the first frame runs, stop2=1 -> no idle bit between the second stop bit and the next start; tx_ready returns high one cycle after the second START entry.
- Width: DATA_WIDTH=5, tx_data=5'h1F, par_odd=1, tick held high -> 0,1,1,1,1,1,0,1 over 8 cycles.
- Reset mid-frame: reset pulses during data bit 3 with the buffer full -> next cycle tx_out=1, busy=0, tx_ready=1; no frame_done; line stays idle.
- Break (UART_TX_BREAK_EN defined): tx_break high for 3 ticks -> tx_out low for 3 tick intervals, then one stop bit, then IDLE; frame_done stays 0.
